inst_fetch_queue: RTL and testbench

Instruction fetch front end for the MIPS core. It issues word fetches to instruction memory and buffers the returned words with their PCs in a small in-order queue. It presents the queue head to the decode stage, which splits the word into opcode/rs/rt/rd/sa/funct/immed fields. Branch, jump and exception redirects flush the queue and discard any in-flight fetch.

---
 rtl/inst_fetch_queue.sv | 145 ++++++++++++++
 tb/tb_inst_fetch_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end.
// Issues word fetches to instruction memory, one at a time. Returned words are
// buffered with their PCs in an in-order queue, and the queue head is presented
// to decode. A redirect flushes the queue and discards any in-flight fetch.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      fetch_pc;
    logic [31:0]      req_pc;      // PC of the request currently granted
    logic [31:0]      q_word [DEPTH];
    logic [31:0]      q_pc   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             grant;
    logic             push;
    logic             pop;
    logic             space_ok;

    // A response is only accepted in WAIT; a redirect kills both push and pop.
    assign grant      = (state == REQ) && imem_gnt;
    assign push       = (state == WAIT) && imem_rvalid && !redirect;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready && !redirect;

    // Occupancy after this cycle's push/pop; a new fetch needs a free slot left.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    assign space_ok = (count_next < CNT_W'(DEPTH));

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: nonblocking assignments in clocked blocks so every register samples pre-edge values.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; a redirect overrides the normal fetch flow.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (space_ok) state_next = REQ;
            REQ:     if (imem_gnt) state_next = WAIT;
            WAIT:    if (imem_rvalid) state_next = space_ok ? REQ : IDLE;
            DROP:    if (imem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (redirect) begin
            case (state)
                REQ:     state_next = imem_gnt ? DROP : IDLE;
                WAIT:    state_next = imem_rvalid ? IDLE : DROP;
                DROP:    state_next = imem_rvalid ? IDLE : DROP;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs: request is a pure function of state, address is the fetch PC.
    always_comb begin
        imem_req  = (state == REQ);
        imem_addr = fetch_pc;
    end

    // Fetch PC, request PC and queue bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (grant) begin
                req_pc <= fetch_pc;
            end
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count_next;
            end
        end
    end

    // Queue storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is reset on purpose; without that requirement it would be left unreset.
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_word[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (push) begin
            q_word[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= req_pc;
        end
    end

    assign inst    = q_word[rd_ptr];
    assign inst_pc = q_pc[rd_ptr];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue.
// The driver plays instruction memory and decode, and it keeps a reference
// model of the fetch stream. The model tracks the next fetch PC, the single
// outstanding request and whether that request was orphaned by a redirect.
// Words expected at decode are pushed into a scoreboard queue. A separate
// monitor compares the queue head whenever the DUT shows a valid instruction.
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    // Reference model state.
    entry_t      sb[$];
    logic [31:0] model_pc;
    logic [31:0] req_pc_m;
    bit          outstanding;
    bit          orphan;

    int n_pass   = 0;
    int n_total  = 0;
    int n_grants = 0;
    int g0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One memory/decode cycle: sample at the falling edge, drive inputs, update model.
    task automatic drive(input bit gnt, input bit rv, input logic [31:0] rdata,
                         input bit rdy, input bit redir, input logic [31:0] rpc);
        bit     granted;
        bit     responded;
        entry_t e;
        @(negedge clk);
        check("inst_valid_vs_model", 32'(inst_valid), 32'(sb.size() != 0));
        if (imem_req) begin
            check("req_while_outstanding", 32'(outstanding), 32'd0);
            check("req_without_space", 32'(sb.size() < DEPTH), 32'd1);
        end
        granted     = imem_req && gnt;
        responded   = rv && outstanding;
        imem_gnt    = gnt;
        imem_rvalid = responded;
        imem_rdata  = rdata;
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        if (responded) begin
            if (!orphan && !redir) begin
                e.pc   = req_pc_m;
                e.word = rdata;
                sb.push_back(e);
            end
            outstanding = 1'b0;
        end
        if (granted) begin
            n_grants++;
            check("imem_addr_at_grant", imem_addr, model_pc);
            req_pc_m    = model_pc;
            model_pc    = model_pc + 32'd4;
            outstanding = 1'b1;
            orphan      = 1'b0;
        end
        if (redir) begin
            sb.delete();
            model_pc = {rpc[31:2], 2'b00};
            if (outstanding) orphan = 1'b1;
        end
    endtask

    // Hold reset low for a number of cycles while memory keeps responding.
    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        sb.delete();
        outstanding = 1'b0;
        orphan      = 1'b0;
        model_pc    = RESET_PC;
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
    endtask

    // Step until a request is visible; the first step never grants.
    task automatic wait_req(input string name);
        int n = 0;
        drive(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);
        while (!imem_req && n < 20) begin
            drive(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);
            n++;
        end
        check(name, 32'(imem_req), 32'd1);
    endtask

    // Monitor: compare the head whenever decode sees a valid instruction.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset && !redirect && inst_valid) begin
                if (sb.size() == 0) begin
                    check("head_without_model_entry", 32'(inst_valid), 32'd0);
                end else begin
                    check("inst_word", inst, sb[0].word);
                    check("inst_pc", inst_pc, sb[0].pc);
                    if (inst_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        reset       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        inst_ready  = 1'b0;
        model_pc    = RESET_PC;
        req_pc_m    = RESET_PC;
        outstanding = 1'b0;
        orphan      = 1'b0;

        // Reset values.
        do_reset(3);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);

        // Immediate grant and response: BFC00000, 04, 08 at one per two cycles.
        g0 = n_grants;
        drive(1'b1, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);
        check("req_rises_cycle1", 32'(imem_req), 32'd1);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);
        check("stream_grants_in_6_cycles", 32'(n_grants - g0), 32'd3);

        // Decode stalled: exactly DEPTH entries fill, then one pop frees one fetch.
        do_reset(1);
        g0 = n_grants;
        repeat (12) drive(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 32'd0);
        check("fill_grants", 32'(n_grants - g0), 32'(DEPTH));
        check("full_req_low", 32'(imem_req), 32'd0);
        check("full_inst_valid", 32'(inst_valid), 32'd1);
        g0 = n_grants;
        drive(1'b1, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);
        repeat (8) drive(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 32'd0);
        check("one_pop_one_grant", 32'(n_grants - g0), 32'd1);
        check("refull_req_low", 32'(imem_req), 32'd0);

        // Redirect while waiting; the orphaned DEADBEEF response is dropped.
        do_reset(1);
        repeat (4) drive(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h8000_0123);
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        check("wait_redir_flushed", 32'(inst_valid), 32'd0);
        check("wait_redir_drop_req", 32'(imem_req), 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("wait_redir_idle_req", 32'(imem_req), 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("wait_redir_new_req", 32'(imem_req), 32'd1);
        check("wait_redir_new_addr", imem_addr, 32'h8000_0120);
        repeat (4) drive(1'b1, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);

        // Redirect in the same cycle as a grant: the next response is dropped.
        wait_req("gnt_redir_req_seen");
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_1000);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("gnt_redir_drop_req", 32'(imem_req), 32'd0);
        check("gnt_redir_flushed", 32'(inst_valid), 32'd0);
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        check("gnt_redir_drop_req2", 32'(imem_req), 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("gnt_redir_idle_req", 32'(imem_req), 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("gnt_redir_new_req", 32'(imem_req), 32'd1);
        check("gnt_redir_new_addr", imem_addr, 32'h0000_1000);

        // PC wrap from the top of the address space.
        drive(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        wait_req("wrap_req_seen");
        check("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        drive(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);
        wait_req("wrap_req_seen2");
        check("wrap_zero_addr", imem_addr, 32'h0000_0000);

        // Reset in WAIT with three queued entries; fetch restarts at RESET_PC.
        do_reset(1);
        repeat (7) drive(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 32'd0);
        check("pre_reset_valid", 32'(inst_valid), 32'd1);
        do_reset(1);
        check("midrst_inst_valid", 32'(inst_valid), 32'd0);
        check("midrst_imem_req", 32'(imem_req), 32'd0);
        check("midrst_imem_addr", imem_addr, RESET_PC);
        check("midrst_inst", inst, 32'd0);
        check("midrst_inst_pc", inst_pc, 32'd0);
        drive(1'b1, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);
        check("midrst_restart_req", 32'(imem_req), 32'd1);
        check("midrst_restart_addr", imem_addr, RESET_PC);

        // Random traffic with occasional redirects.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0), $urandom);
        end
        repeat (20) drive(1'b1, 1'b1, $urandom, 1'b1, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
